misr_compactor: RTL

MISR_COMPACTOR -- requirements
Module: misr_compactor

---
 rtl/misr_compactor.sv | 76 +++++++
 1 files changed

// File: rtl/misr_compactor.sv
// Multiple-input signature register with run control: compacts a counted burst of
// response vectors into a signature and compares it against a golden value.
module misr_compactor #(
   parameter int unsigned      WIDTH = 16,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(16'h1021),
   parameter int unsigned      CNT_W = 16
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             start,
   input  logic [WIDTH-1:0] seed,
   input  logic [CNT_W-1:0] num_patterns,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic [WIDTH-1:0] golden,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH-1:0] signature,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_q;
   logic [CNT_W-1:0] r_cnt;
   logic             r_pass;

   logic [WIDTH-1:0] w_next;
   logic             w_step;

   // Shift toward the MSB; the MSB folds back into every tapped stage.
   assign w_next = in_data ^ {r_q[WIDTH-2:0], 1'b0} ^ (POLY & {WIDTH{r_q[WIDTH-1]}});
   assign w_step = (r_state == S_RUN) && in_valid;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= S_IDLE;
         r_q     <= '0;
         r_cnt   <= '0;
         r_pass  <= 1'b0;
      end else if (start) begin
         // start wins over a beat in the same cycle, from any state
         r_q   <= seed;
         r_cnt <= num_patterns;
         if (num_patterns == '0) begin
            r_state <= S_DONE;
            r_pass  <= (seed == golden);
         end else begin
            r_state <= S_RUN;
            r_pass  <= 1'b0;
         end
      end else if (w_step) begin
         r_q   <= w_next;
         r_cnt <= r_cnt - CNT_W'(1);
         if (r_cnt == CNT_W'(1)) begin
            r_state <= S_DONE;
            r_pass  <= (w_next == golden);
         end
      end
   end

   assign in_ready  = (r_state == S_RUN);
   assign busy      = in_ready;
   assign done      = (r_state == S_DONE);
   assign pass      = r_pass;
   assign signature = r_q;
   assign dbg_state = r_state;

endmodule
